decode_cycle: RTL and testbench

Instruction-decode (ID) stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. Decodes the instruction in ID, reads the 32×32 register file, and sign-extends the immediate. It then captures all control and data fields in the ID/EX pipeline register for the execute stage. It also holds the register-file write port driven by write-back, and supports a synchronous squash of the ID/EX register.

---
 rtl/decode_cycle_if.sv | 44 ++++
 rtl/decode_cycle.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_cycle_if.sv
// decode_cycle_if: bundles the ID-stage inputs (instruction, PCs, write-back
// port, squash) and the ID/EX register outputs handed to the execute stage.
interface decode_cycle_if;
   // ID-stage inputs
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        FlushE;
   // ID/EX register outputs
   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic        MemWriteE;
   logic        JumpE;
   logic        BranchE;
   logic        ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E;
   logic [31:0] RD2_E;
   logic [31:0] Imm_Ext_E;
   logic [4:0]  RS1_E;
   logic [4:0]  RS2_E;
   logic [4:0]  RD_E;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;

   // Pipeline side: drives ID inputs, consumes EX outputs
   modport master (
      output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
      input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
             ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E,
             PCE, PCPlus4E
   );

   // Decode stage side
   modport slave (
      input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
      output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
             ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E,
             PCE, PCPlus4E
   );
endinterface

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I instruction-decode stage. Combinational decode,
// register-file read with write-through, immediate extension, and the
// ID/EX pipeline register with synchronous squash.
module decode_cycle (
   input  logic          clk,
   input  logic          rst,    // asynchronous, active-low
   decode_cycle_if.slave bus
);
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Instruction fields
   logic [31:0] w_instr;
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;

   assign w_instr  = bus.InstrD;
   assign w_opcode = w_instr[6:0];
   assign w_funct3 = w_instr[14:12];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];
   assign w_rd     = w_instr[11:7];

   // Immediate formats, all sign-extended from instr[31]
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_j;

   assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25],
                     w_instr[11:8], 1'b0};
   assign w_imm_j = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                     w_instr[30:21], 1'b0};

   // Decoded controls
   logic        w_reg_write;
   logic [1:0]  w_result_src;
   logic        w_mem_write;
   logic        w_jump;
   logic        w_branch;
   logic        w_alu_src;
   logic [2:0]  w_alu_ctrl;
   logic [31:0] w_imm;
   logic        w_alu_from_funct;

   // Main decoder and ALU decoder; unsupported opcodes leave everything 0
   always_comb begin
      w_reg_write      = 1'b0;
      w_result_src     = 2'b00;
      w_mem_write      = 1'b0;
      w_jump           = 1'b0;
      w_branch         = 1'b0;
      w_alu_src        = 1'b0;
      w_alu_ctrl       = ALU_ADD;
      w_imm            = 32'd0;
      w_alu_from_funct = 1'b0;

      case (w_opcode)
         OP_LW: begin
            w_reg_write  = 1'b1;
            w_result_src = 2'b01;
            w_alu_src    = 1'b1;
            w_imm        = w_imm_i;
         end
         OP_SW: begin
            w_mem_write = 1'b1;
            w_alu_src   = 1'b1;
            w_imm       = w_imm_s;
         end
         OP_R: begin
            w_reg_write      = 1'b1;
            w_alu_from_funct = 1'b1;
         end
         OP_I: begin
            w_reg_write      = 1'b1;
            w_alu_src        = 1'b1;
            w_imm            = w_imm_i;
            w_alu_from_funct = 1'b1;
         end
         OP_BEQ: begin
            w_branch   = 1'b1;
            w_imm      = w_imm_b;
            w_alu_ctrl = ALU_SUB;
         end
         OP_JAL: begin
            w_reg_write  = 1'b1;
            w_result_src = 2'b10;
            w_jump       = 1'b1;
            w_imm        = w_imm_j;
         end
         default: ;
      endcase

      // opcode[5] separates R-type from I-ALU so addi with instr[30]=1 stays add
      if (w_alu_from_funct) begin
         case (w_funct3)
            3'b000:  w_alu_ctrl = (w_opcode[5] && w_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_ctrl = ALU_SLT;
            3'b110:  w_alu_ctrl = ALU_OR;
            3'b111:  w_alu_ctrl = ALU_AND;
            default: w_alu_ctrl = ALU_ADD;
         endcase
      end
   end

   // Register file: x0 is a hard zero, x1..x31 are individual registers
   logic [31:0][31:0] w_rf;
   assign w_rf[0] = 32'd0;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_rf
         logic [31:0] r_q;

         // Write-back commits on the edge regardless of FlushE
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               r_q <= 32'd0;
            else if (bus.RegWriteW && (bus.RDW == 5'(gi)))
               r_q <= bus.ResultW;
         end

         assign w_rf[gi] = r_q;
      end
   endgenerate

   // Read ports with write-through of the same-cycle write-back value
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;

   assign w_rd1 = (w_rs1 == 5'd0) ? 32'd0 :
                  (bus.RegWriteW && (bus.RDW == w_rs1)) ? bus.ResultW : w_rf[w_rs1];
   assign w_rd2 = (w_rs2 == 5'd0) ? 32'd0 :
                  (bus.RegWriteW && (bus.RDW == w_rs2)) ? bus.ResultW : w_rf[w_rs2];

   // ID/EX pipeline register
   logic        r_reg_write;
   logic [1:0]  r_result_src;
   logic        r_mem_write;
   logic        r_jump;
   logic        r_branch;
   logic        r_alu_src;
   logic [2:0]  r_alu_ctrl;
   logic [31:0] r_rd1;
   logic [31:0] r_rd2;
   logic [31:0] r_imm;
   logic [4:0]  r_rs1;
   logic [4:0]  r_rs2;
   logic [4:0]  r_rd;
   logic [31:0] r_pc;
   logic [31:0] r_pc_plus4;

   // Capture decode results every edge; FlushE loads an all-zero bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || bus.FlushE) begin
         r_reg_write  <= 1'b0;
         r_result_src <= 2'b00;
         r_mem_write  <= 1'b0;
         r_jump       <= 1'b0;
         r_branch     <= 1'b0;
         r_alu_src    <= 1'b0;
         r_alu_ctrl   <= 3'b000;
         r_rd1        <= 32'd0;
         r_rd2        <= 32'd0;
         r_imm        <= 32'd0;
         r_rs1        <= 5'd0;
         r_rs2        <= 5'd0;
         r_rd         <= 5'd0;
         r_pc         <= 32'd0;
         r_pc_plus4   <= 32'd0;
      end else begin
         r_reg_write  <= w_reg_write;
         r_result_src <= w_result_src;
         r_mem_write  <= w_mem_write;
         r_jump       <= w_jump;
         r_branch     <= w_branch;
         r_alu_src    <= w_alu_src;
         r_alu_ctrl   <= w_alu_ctrl;
         r_rd1        <= w_rd1;
         r_rd2        <= w_rd2;
         r_imm        <= w_imm;
         r_rs1        <= w_rs1;
         r_rs2        <= w_rs2;
         r_rd         <= w_rd;
         r_pc         <= bus.PCD;
         r_pc_plus4   <= bus.PCPlus4D;
      end
   end

   assign bus.RegWriteE   = r_reg_write;
   assign bus.ResultSrcE  = r_result_src;
   assign bus.MemWriteE   = r_mem_write;
   assign bus.JumpE       = r_jump;
   assign bus.BranchE     = r_branch;
   assign bus.ALUSrcE     = r_alu_src;
   assign bus.ALUControlE = r_alu_ctrl;
   assign bus.RD1_E       = r_rd1;
   assign bus.RD2_E       = r_rd2;
   assign bus.Imm_Ext_E   = r_imm;
   assign bus.RS1_E       = r_rs1;
   assign bus.RS2_E       = r_rs2;
   assign bus.RD_E        = r_rd;
   assign bus.PCE         = r_pc;
   assign bus.PCPlus4E    = r_pc_plus4;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed checks of the decode stage. Each step drives one
// instruction, pushes its expected ID/EX contents to a scoreboard queue, and
// pops/compares after the capturing edge.
module tb_decode_cycle;
   typedef struct packed {
      logic [6:0]  ctrl;   // {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc}
      logic [2:0]  alu;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   localparam logic [6:0] CT_NONE = 7'b0_00_0_0_0_0;
   localparam logic [6:0] CT_R    = 7'b1_00_0_0_0_0;
   localparam logic [6:0] CT_I    = 7'b1_00_0_0_0_1;
   localparam logic [6:0] CT_LW   = 7'b1_01_0_0_0_1;
   localparam logic [6:0] CT_SW   = 7'b0_00_1_0_0_1;
   localparam logic [6:0] CT_BEQ  = 7'b0_00_0_0_1_0;
   localparam logic [6:0] CT_JAL  = 7'b1_10_0_1_0_0;

   localparam logic [2:0] A_ADD = 3'b000;
   localparam logic [2:0] A_SUB = 3'b001;
   localparam logic [2:0] A_AND = 3'b010;
   localparam logic [2:0] A_OR  = 3'b011;
   localparam logic [2:0] A_SLT = 3'b101;

   logic clk;
   logic rst;
   decode_cycle_if bus();

   decode_cycle dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pc       = 32'h0000_1000;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic exp_t mk(input logic [6:0] c, input logic [2:0] a,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] im, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [4:0] d);
      exp_t e;
      e      = '0;
      e.ctrl = c;
      e.alu  = a;
      e.rd1  = r1;
      e.rd2  = r2;
      e.imm  = im;
      e.rs1  = s1;
      e.rs2  = s2;
      e.rd   = d;
      return e;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o = {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
           bus.ALUSrcE, bus.ALUControlE, bus.RD1_E, bus.RD2_E, bus.Imm_Ext_E,
           bus.RS1_E, bus.RS2_E, bus.RD_E, bus.PCE, bus.PCPlus4E};
      return o;
   endfunction

   task automatic check_zero(input string tag);
      exp_t got;
      exp_t want;
      got  = observe();
      want = '0;
      n_checks++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
      $display("check %-10s outputs=%h", tag, got);
   endtask

   task automatic step(input string tag, input logic [31:0] instr,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
                       input logic flush, input exp_t e);
      exp_t got;
      exp_t want;
      exp_t pushed;
      bus.InstrD    = instr;
      bus.PCD       = pc;
      bus.PCPlus4D  = pc + 32'd4;
      bus.RegWriteW = wen;
      bus.RDW       = wrd;
      bus.ResultW   = wdat;
      bus.FlushE    = flush;
      pushed = e;
      if (flush) begin
         pushed = '0;
      end else begin
         pushed.pc  = pc;
         pushed.pc4 = pc + 32'd4;
      end
      sb_q.push_back(pushed);
      @(posedge clk);
      #1;
      pc  = pc + 32'd4;
      got = observe();
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         want = sb_q.pop_front();
         assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
         end
      end
      $display("step  %-10s instr=%h rd1=%h rd2=%h imm=%h alu=%b", tag, instr,
               got.rd1, got.rd2, got.imm, got.alu);
   endtask

   initial begin
      // Reset with random inputs present: every output must be 0
      rst           = 1'b0;
      bus.InstrD    = $urandom;
      bus.PCD       = $urandom;
      bus.PCPlus4D  = $urandom;
      bus.RegWriteW = 1'b1;
      bus.RDW       = 5'd1;
      bus.ResultW   = $urandom;
      bus.FlushE    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // All registers read 0 after reset (pairs cover x1..x31)
      for (int k = 1; k <= 16; k++) begin
         step("rd_zero", enc_r(7'd0, 5'(32 - k), 5'(k), 3'b000, 5'd0), 1'b0, 5'd0, 32'd0, 1'b0,
              mk(CT_R, A_ADD, 32'd0, 32'd0, 32'd0, 5'(k), 5'(32 - k), 5'd0));
      end

      // Write-back x1=5, x2=7 (unsupported opcode 0 in ID), then add x3,x1,x2
      step("wr_x1", 32'h0000_0000, 1'b1, 5'd1, 32'd5, 1'b0,
           mk(CT_NONE, A_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0));
      step("wr_x2", 32'h0000_0000, 1'b1, 5'd2, 32'd7, 1'b0,
           mk(CT_NONE, A_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0));
      step("add", 32'h0020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_ADD, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3));

      // Write-through: x1 written in the same cycle addi x2,x1,0 reads it
      step("wthru", 32'h0000_8113, 1'b1, 5'd1, 32'hDEAD_BEEF, 1'b0,
           mk(CT_I, A_ADD, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd1, 5'd0, 5'd2));
      // Writes to x0 are discarded, both forwarded and stored
      step("x0_wr", 32'h0000_01B3, 1'b1, 5'd0, 32'd9, 1'b0,
           mk(CT_R, A_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd3));
      step("x0_rd", 32'h0000_01B3, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd3));
      step("persist", 32'h0020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_ADD, 32'hDEAD_BEEF, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3));

      // Immediate formats
      step("lw", 32'hFFC1_2083, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_LW, A_ADD, 32'd7, 32'd0, 32'hFFFF_FFFC, 5'd2, 5'd28, 5'd1));
      step("sw", 32'hFE11_2E23, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_SW, A_ADD, 32'd7, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd2, 5'd1, 5'd28));
      step("beq", 32'hFE20_8EE3, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_BEQ, A_SUB, 32'hDEAD_BEEF, 32'd7, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd29));
      step("jal", 32'h0080_006F, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_JAL, A_ADD, 32'd0, 32'd0, 32'd8, 5'd0, 5'd8, 5'd0));

      // Flush with a concurrent write-back: bubble in ID/EX, write commits
      step("flush", 32'h0020_81B3, 1'b1, 5'd4, 32'h0000_1234, 1'b1, '0);
      step("resume", 32'h0022_02B3, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_ADD, 32'h0000_1234, 32'd7, 32'd0, 5'd4, 5'd2, 5'd5));

      // ALU decode
      step("sub", 32'h4020_8233, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_SUB, 32'hDEAD_BEEF, 32'd7, 32'd0, 5'd1, 5'd2, 5'd4));
      step("slt", enc_r(7'd0, 5'd2, 5'd1, 3'b010, 5'd6), 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_SLT, 32'hDEAD_BEEF, 32'd7, 32'd0, 5'd1, 5'd2, 5'd6));
      step("or", enc_r(7'd0, 5'd2, 5'd1, 3'b110, 5'd6), 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_OR, 32'hDEAD_BEEF, 32'd7, 32'd0, 5'd1, 5'd2, 5'd6));
      step("and", enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd6), 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_AND, 32'hDEAD_BEEF, 32'd7, 32'd0, 5'd1, 5'd2, 5'd6));
      step("addi_b30", 32'h4000_8393, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_I, A_ADD, 32'hDEAD_BEEF, 32'd0, 32'h0000_0400, 5'd1, 5'd0, 5'd7));
      step("op_7f", 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_NONE, A_ADD, 32'd0, 32'd0, 32'd0, 5'd31, 5'd31, 5'd31));

      // Mid-operation reset clears outputs without a clock edge, then registers read 0
      rst           = 1'b0;
      bus.RegWriteW = 1'b0;
      #1;
      check_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      step("post_rst", 32'h0020_81B3, 1'b0, 5'd0, 32'd0, 1'b0,
           mk(CT_R, A_ADD, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
